// File: rtl/uart_inst_collector.sv
// uart_inst_collector: packs UART RX bytes into the decoder's instruction buffer,
// detects end of frame (length + LF, or full buffer), pulses end_of_inst, then
// freezes the buffer until the hold time has elapsed and the backend is idle.
// Stalled frames are discarded on an idle timeout; bytes arriving while the buffer
// is frozen are dropped and flagged on the sticky overrun output.
module uart_inst_collector #(
  parameter int unsigned IBUF_SZ     = 11,
  parameter int unsigned IBUF_DW     = 8,
  parameter int unsigned IBUF_AW     = 4,
  parameter int unsigned MIN_LEN     = 11,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned HOLD_CYC    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       backend_busy,
  input  logic                       ovr_clr,
  output logic                       end_of_inst,
  output logic [IBUF_SZ*IBUF_DW-1:0] ibuf_dec,
  output logic [IBUF_AW-1:0]         ibuf_cnt_dec,
  output logic                       frame_busy,
  output logic                       timeout_pls,
  output logic                       overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);

  localparam logic [IBUF_AW-1:0] SZ_C    = IBUF_AW'(IBUF_SZ);
  localparam logic [IBUF_AW-1:0] MIN_C   = IBUF_AW'(MIN_LEN);
  localparam logic [TW-1:0]      TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0]      HOLD_C  = HW'(HOLD_CYC);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IBUF_AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]      idle_q, idle_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               tmo_q, tmo_d;
  logic               ovr_q, ovr_d;
  logic [IBUF_DW-1:0] buf_q [IBUF_SZ];

  logic               wr_en;
  logic [IBUF_AW-1:0] wr_idx;
  logic [IBUF_AW-1:0] new_cnt;
  logic               frame_end;
  logic               frozen;

  assign frozen    = (state_q == ST_EMIT) || (state_q == ST_HOLD);
  assign new_cnt   = cnt_q + IBUF_AW'(1);
  // An early LF is payload (binary fields may contain 0x0A); only a late LF or a full buffer ends the frame.
  assign frame_end = ((rx_data == 8'h0A) && (new_cnt >= MIN_C)) || (new_cnt == SZ_C);

  // Next-state logic: frame FSM, byte counter, idle/hold counters, overrun flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = '0;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data != 8'h0D) && (rx_data != 8'h0A)) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          cnt_d   = IBUF_AW'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          cnt_d = new_cnt;
          if (frame_end) state_d = ST_EMIT;
        end else if (idle_q == TO_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
      ST_EMIT: begin
        hold_d  = '0;
        state_d = ST_HOLD;
      end
      default: begin
        if ((hold_q == HOLD_C) && !backend_busy) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (hold_q != HOLD_C) begin
          hold_d = hold_q + HW'(1);
        end
      end
    endcase
    // Set is evaluated after clear so a simultaneous drop still records the overrun.
    if (ovr_clr) ovr_d = 1'b0;
    if (rx_valid && frozen) ovr_d = 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  // Instruction buffer: one entry written per accepted byte, never cleared except by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < IBUF_SZ; i++) buf_q[i] <= '0;
    end else if (wr_en && (wr_idx < SZ_C)) begin
      buf_q[wr_idx] <= IBUF_DW'(rx_data);
    end
  end

  // Pack buffer entries for the decoder, entry 0 in the low bits.
  always_comb begin
    ibuf_dec = '0;
    for (int unsigned i = 0; i < IBUF_SZ; i++) ibuf_dec[i*IBUF_DW +: IBUF_DW] = buf_q[i];
  end

  assign end_of_inst  = (state_q == ST_EMIT);
  assign frame_busy   = frozen;
  assign timeout_pls  = tmo_q;
  assign overrun      = ovr_q;
  assign ibuf_cnt_dec = cnt_q;

endmodule

// File: tb/tb_uart_inst_collector.sv
// Self-checking bench for uart_inst_collector: directed frames plus randomized
// frames checked against a byte-list reference model of the framing rules.
module tb_uart_inst_collector;

  localparam int SZ   = 11;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int MINL = 11;
  localparam int TO   = 200;
  localparam int HC   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              backend_busy = 1'b0;
  logic              ovr_clr = 1'b0;
  logic              end_of_inst;
  logic [SZ*DW-1:0]  ibuf_dec;
  logic [AW-1:0]     ibuf_cnt_dec;
  logic              frame_busy;
  logic              timeout_pls;
  logic              overrun;

  uart_inst_collector #(
    .IBUF_SZ(SZ), .IBUF_DW(DW), .IBUF_AW(AW),
    .MIN_LEN(MINL), .TIMEOUT_CYC(TO), .HOLD_CYC(HC)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .backend_busy(backend_busy), .ovr_clr(ovr_clr), .end_of_inst(end_of_inst),
    .ibuf_dec(ibuf_dec), .ibuf_cnt_dec(ibuf_cnt_dec), .frame_busy(frame_busy),
    .timeout_pls(timeout_pls), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes of the frame in progress plus the persistent buffer image.
  logic [7:0] exp_buf [SZ];
  int         exp_len = 0;
  logic       exp_ovr = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_image();
    logic [127:0] p = '0;
    for (int i = 0; i < SZ; i++) p[i*8 +: 8] = exp_buf[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SZ; i++) exp_buf[i] = 8'h00;
    exp_len = 0;
    exp_ovr = 1'b0;
  endtask

  // Framing rules: leading CR/LF skipped; frame ends on late LF or when full.
  task automatic model_push(input logic [7:0] b, output bit done);
    done = 1'b0;
    if (exp_len == 0 && (b == 8'h0D || b == 8'h0A)) return;
    exp_buf[exp_len] = b;
    exp_len++;
    done = ((b == 8'h0A) && (exp_len >= MINL)) || (exp_len == SZ);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit done);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_push(b, done);
    check_val("eoi", end_of_inst, done);
    check_val("cnt", ibuf_cnt_dec, exp_len);
    check_val("buf", ibuf_dec, model_image());
  endtask

  // Called on the sample right after end_of_inst; waits out the frozen period.
  task automatic finish_frame(input int busy_cyc);
    int held = 0;
    logic [127:0] img = model_image();
    backend_busy = (busy_cyc > 0);
    @(negedge clk);
    check_val("eoi_one_cycle", end_of_inst, 1'b0);
    check_val("frozen", frame_busy, 1'b1);
    for (int c = 0; c < busy_cyc + 20 && frame_busy; c++) begin
      held++;
      if (c + 1 >= busy_cyc) backend_busy = 1'b0;
      @(negedge clk);
      if (frame_busy) begin
        check_val("hold_buf", ibuf_dec, img);
        check_val("hold_cnt", ibuf_cnt_dec, exp_len);
      end
    end
    backend_busy = 1'b0;
    check_val("hold_exit", frame_busy, 1'b0);
    check_val("hold_min", (held >= HC) && (held >= busy_cyc), 1'b1);
    exp_len = 0;
    check_val("idle_cnt", ibuf_cnt_dec, 0);
    check_val("idle_buf", ibuf_dec, img);
  endtask

  task automatic send_frame(input logic [7:0] bytes [$], input int busy_cyc);
    bit done = 1'b0;
    foreach (bytes[i]) begin
      send_byte(bytes[i], 0, done);
      if (done) break;
    end
    check_val("frame_done", done, 1'b1);
    if (done) finish_frame(busy_cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_eoi"}, end_of_inst, 1'b0);
    check_val({tag, "_buf"}, ibuf_dec, '0);
    check_val({tag, "_cnt"}, ibuf_cnt_dec, 0);
    check_val({tag, "_busy"}, frame_busy, 1'b0);
    check_val({tag, "_tmo"}, timeout_pls, 1'b0);
    check_val({tag, "_ovr"}, overrun, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_all_zero("rst");
    rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] q [$];
    bit done;
    int c;

    model_reset();
    #1 check_all_zero("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Test 1: basic frame.
    q = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0D, 8'h0A};
    send_frame(q, 0);
    check_val("t1_entry0", ibuf_dec[7:0], 8'h57);
    check_val("t1_entry10", ibuf_dec[87:80], 8'h0A);

    // Test 2: leading CR/LF ignored.
    q = '{8'h0D, 8'h0A, 8'h52, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0D, 8'h0A};
    send_frame(q, 2);
    check_val("t2_entry0", ibuf_dec[7:0], 8'h52);

    // Test 3: early LF is payload.
    q = '{8'h52, 8'h00, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h0D, 8'h0A};
    send_frame(q, 0);
    check_val("t3_entry2", ibuf_dec[23:16], 8'h0A);

    // Randomized frames with random gaps, LF density and backend busy time.
    for (int f = 0; f < 25; f++) begin
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
        logic [7:0] b;
        b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
        send_byte(b, $urandom_range(0, 2), done);
      end
      check_val("rnd_done", done, 1'b1);
      if (done) finish_frame($urandom_range(0, 8));
    end

    // Test 4: stalled frame discarded by timeout.
    q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    foreach (q[i]) send_byte(q[i], 0, done);
    c = 0;
    while (!timeout_pls && c < TO + 20) begin
      @(negedge clk);
      c++;
      check_val("t4_no_eoi", end_of_inst, 1'b0);
    end
    check_val("t4_pulse", timeout_pls, 1'b1);
    check_val("t4_delay", (c >= TO - 1) && (c <= TO + 1), 1'b1);
    check_val("t4_cnt", ibuf_cnt_dec, 0);
    @(negedge clk);
    check_val("t4_one_pulse", timeout_pls, 1'b0);
    exp_len = 0;
    q = '{8'h57, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h0D, 8'h0A};
    send_frame(q, 0);

    // Test 5: byte during HOLD with busy backend is dropped and flagged.
    q = '{8'h57, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0D, 8'h0A};
    foreach (q[i]) send_byte(q[i], 0, done);
    backend_busy = 1'b1;
    @(negedge clk);
    rx_data = 8'h77;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check_val("t5_ovr", overrun, 1'b1);
    check_val("t5_buf", ibuf_dec, model_image());
    check_val("t5_cnt", ibuf_cnt_dec, SZ);
    repeat (18) @(negedge clk);
    check_val("t5_still_frozen", frame_busy, 1'b1);
    backend_busy = 1'b0;
    c = 0;
    while (frame_busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    exp_len = 0;
    check_val("t5_idle", frame_busy, 1'b0);
    check_val("t5_ovr_sticky", overrun, 1'b1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check_val("t5_ovr_clr", overrun, 1'b0);

    // Overrun set and clear in the same cycle: set wins.
    foreach (q[i]) send_byte(q[i], 0, done);
    rx_valid = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    ovr_clr = 1'b0;
    check_val("t5_set_wins", overrun, 1'b1);
    repeat (10) @(negedge clk);
    exp_len = 0;
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check_val("t5_clr2", overrun, 1'b0);

    // Test 6: reset mid-frame at byte 6, then a full frame.
    q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    foreach (q[i]) send_byte(q[i], 0, done);
    @(negedge clk);
    rx_data = 8'h66;
    rx_valid = 1'b1;
    async_reset();
    check_all_zero("t6_after");
    q = '{8'h57, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA};
    send_frame(q, 0);

    // Reset during HOLD.
    foreach (q[i]) send_byte(q[i], 0, done);
    @(negedge clk);
    async_reset();
    check_all_zero("hold_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
